ultrasonic_ranger: RTL and testbench

- Drives an HC-SR04-style ultrasonic sensor: issues trigger pulses, times the echo pulse and converts its width to distance in centimetres.
- Sits directly upstream of the 7-segment display driver on the miniCar. Its data_out feeds the display's distance input, which shows the 16 LSBs as four BCD digits.
- Width-to-cm conversion uses a µs sub-counter feeding a 4-digit BCD counter, so no divider and no binary-to-BCD stage is needed.

---
 rtl/ultrasonic_ranger.sv | 201 ++++++++++++++++++++
 tb/tb_ultrasonic_ranger.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_ranger.sv
// HC-SR04 style ranger: periodic trigger, echo width timing, BCD centimetre result.
// Optional DIST_HOLD_LAST_EN keeps the previous distance on timeout/overlength.
module ultrasonic_ranger #(
    parameter int CLK_FREQ_HZ  = 100000000,
    parameter int TRIG_US      = 10,
    parameter int ECHO_WAIT_US = 25000,
    parameter int ECHO_MAX_US  = 23200,
    parameter int CYCLE_US     = 60000,
    parameter int US_PER_CM    = 58
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        enable,
    input  logic        echo_in,
    output logic        trig_out,
    output logic [31:0] data_out,
    output logic        data_valid,
    output logic        out_of_range
);

    localparam logic [31:0] TICK_LAST  = 32'(CLK_FREQ_HZ / 1000000 - 1);
    localparam logic [31:0] TRIG_LAST  = 32'(TRIG_US - 1);
    localparam logic [31:0] WAIT_LAST  = 32'(ECHO_WAIT_US - 1);
    localparam logic [31:0] ECHO_MAX   = 32'(ECHO_MAX_US);
    localparam logic [31:0] CYCLE_LAST = 32'(CYCLE_US - 1);
    localparam logic [31:0] SUB_LAST   = 32'(US_PER_CM - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_TRIG = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_MEAS = 3'd3;
    localparam logic [2:0] S_HOLD = 3'd4;

    logic [2:0]  state;
    logic [31:0] tick_cnt;
    logic        tick;
    logic        echo_meta_p0, echo_s_p1, echo_s_d_p2;
    logic        rise, fall;
    logic [31:0] us_cnt, cycle_cnt, sub_cnt;
    logic [15:0] bcd;
    logic [31:0] us_nxt, sub_nxt;
    logic [15:0] bcd_nxt;
    logic        meas_start, count_en, over_len, res_ok, res_bad;

    function automatic logic [15:0] bcd_inc_sat(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v == 16'h9999) return v;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk_in) begin
        if (rst || tick) tick_cnt <= '0;
        else             tick_cnt <= tick_cnt + 32'd1;
    end

    // p0..p2: echo synchronizer and edge-detect delay
    always_ff @(posedge clk_in) begin
        if (rst) begin
            echo_meta_p0 <= 1'b0;
            echo_s_p1    <= 1'b0;
            echo_s_d_p2  <= 1'b0;
        end else begin
            echo_meta_p0 <= echo_in;
            echo_s_p1    <= echo_meta_p0;
            echo_s_d_p2  <= echo_s_p1;
        end
    end

    assign rise = echo_s_p1 & ~echo_s_d_p2;
    assign fall = ~echo_s_p1 & echo_s_d_p2;

    // The rise cycle itself is counted so an N us echo always yields exactly N ticks.
    assign meas_start = (state == S_WAIT) && rise;
    assign count_en   = tick && echo_s_p1 && ((state == S_MEAS) || meas_start);

    always_comb begin
        sub_nxt = meas_start ? '0 : sub_cnt;
        bcd_nxt = meas_start ? '0 : bcd;
        us_nxt  = meas_start ? '0 : us_cnt;
        if (count_en) begin
            us_nxt = us_nxt + 32'd1;
            if (sub_nxt == SUB_LAST) begin
                sub_nxt = '0;
                bcd_nxt = bcd_inc_sat(bcd_nxt);
            end else begin
                sub_nxt = sub_nxt + 32'd1;
            end
        end
    end

    assign over_len = count_en && (us_nxt == ECHO_MAX);
    assign res_ok   = (state == S_MEAS) && fall;
    assign res_bad  = over_len ||
                      ((state == S_WAIT) && !rise && tick && (us_cnt == WAIT_LAST));

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state     <= S_IDLE;
            trig_out  <= 1'b0;
            us_cnt    <= '0;
            cycle_cnt <= '0;
            sub_cnt   <= '0;
            bcd       <= '0;
        end else begin
            if (tick) cycle_cnt <= cycle_cnt + 32'd1;
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        state     <= S_TRIG;
                        trig_out  <= 1'b1;
                        us_cnt    <= '0;
                        cycle_cnt <= '0;
                    end
                end
                S_TRIG: begin
                    if (tick) begin
                        if (us_cnt == TRIG_LAST) begin
                            state    <= S_WAIT;
                            trig_out <= 1'b0;
                            us_cnt   <= '0;
                        end else begin
                            us_cnt <= us_cnt + 32'd1;
                        end
                    end
                end
                S_WAIT: begin
                    if (meas_start) begin
                        state   <= over_len ? S_HOLD : S_MEAS;
                        sub_cnt <= sub_nxt;
                        bcd     <= bcd_nxt;
                        us_cnt  <= us_nxt;
                    end else if (res_bad) begin
                        state <= S_HOLD;
                    end else if (tick) begin
                        us_cnt <= us_cnt + 32'd1;
                    end
                end
                S_MEAS: begin
                    if (res_ok || res_bad) begin
                        state <= S_HOLD;
                    end else begin
                        sub_cnt <= sub_nxt;
                        bcd     <= bcd_nxt;
                        us_cnt  <= us_nxt;
                    end
                end
                S_HOLD: begin
                    // Leaving on a tick keeps successive trigger rises exactly CYCLE_US apart.
                    if (tick && (cycle_cnt >= CYCLE_LAST) && !echo_s_p1) begin
                        if (enable) begin
                            state     <= S_TRIG;
                            trig_out  <= 1'b1;
                            us_cnt    <= '0;
                            cycle_cnt <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            data_out     <= '0;
            data_valid   <= 1'b0;
            out_of_range <= 1'b0;
        end else begin
            data_valid <= res_ok || res_bad;
            if (res_ok) begin
                data_out     <= {16'h0000, bcd};
                out_of_range <= 1'b0;
            end else if (res_bad) begin
`ifdef DIST_HOLD_LAST_EN
                out_of_range <= 1'b1;
`else
                data_out     <= 32'h0000_9999;
                out_of_range <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed bench for ultrasonic_ranger, scaled to 4 clk/us and short timing windows.
`timescale 1ns/1ps
module tb_ultrasonic_ranger;

    logic        clk_in = 1'b0;
    logic        rst, enable, echo_in;
    logic        trig_out, data_valid, out_of_range;
    logic [31:0] data_out;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          n, r1, r2, r3, m, seen;

`ifdef DIST_HOLD_LAST_EN
    localparam logic [31:0] EXP_FAULT = 32'h0000_0099;
`else
    localparam logic [31:0] EXP_FAULT = 32'h0000_9999;
`endif

    ultrasonic_ranger #(
        .CLK_FREQ_HZ (4000000),
        .TRIG_US     (3),
        .ECHO_WAIT_US(300),
        .ECHO_MAX_US (250),
        .CYCLE_US    (700),
        .US_PER_CM   (2)
    ) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .enable      (enable),
        .echo_in     (echo_in),
        .trig_out    (trig_out),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .out_of_range(out_of_range)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        tests++;
        assert (obs >= lo && obs <= hi) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic wait_trig(input logic lvl, input int limit, output int cnt);
        cnt = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk_in);
            if (trig_out === lvl) begin
                cnt = i;
                break;
            end
        end
        tests++;
        assert (cnt > 0) else begin
            fails++;
            $error("FAIL trig_wait observed=timeout expected=trig_out=%b", lvl);
        end
    endtask

    task automatic wait_dv(input int limit, output int cnt);
        cnt = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk_in);
            if (data_valid === 1'b1) begin
                cnt = i;
                break;
            end
        end
        tests++;
        assert (cnt > 0) else begin
            fails++;
            $error("FAIL dv_wait observed=timeout expected=data_valid pulse");
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; echo_in = 1'b0;
        repeat (4) @(negedge clk_in);
        chk("rst_trig", {31'd0, trig_out}, 32'd0);
        chk("rst_data", data_out, 32'd0);
        chk("rst_dv", {31'd0, data_valid}, 32'd0);
        chk("rst_oor", {31'd0, out_of_range}, 32'd0);

        // Power-on trigger from IDLE (not tick aligned, so width is 9..12 clk)
        rst = 1'b0; enable = 1'b1;
        wait_trig(1'b1, 5, n);
        chk_rng("trig_start_lat", n, 1, 2);
        wait_trig(1'b0, 20, n);
        chk_rng("trig_first_width", n, 9, 12);

        // 200 us echo at 2 us/cm -> 100 cm
        repeat (40) @(negedge clk_in);
        echo_in = 1'b1;
        repeat (800) @(negedge clk_in);
        echo_in = 1'b0;
        wait_dv(10, n);
        chk_rng("exact_dv_lat", n, 2, 3);
        chk("exact_data", data_out, 32'h0000_0100);
        chk("exact_oor", {31'd0, out_of_range}, 32'd0);
        @(negedge clk_in);
        chk("exact_dv_single", {31'd0, data_valid}, 32'd0);

        // Truncation: 199 us -> 99 cm
        wait_trig(1'b1, 3000, n);
        r1 = cyc;
        wait_trig(1'b0, 20, n);
        chk("trig_width_1", n, 12);
        repeat (40) @(negedge clk_in);
        echo_in = 1'b1;
        repeat (796) @(negedge clk_in);
        echo_in = 1'b0;
        wait_dv(10, n);
        chk("trunc_data", data_out, 32'h0000_0099);
        chk("trunc_oor", {31'd0, out_of_range}, 32'd0);

        // Timeout: no echo, result 300 us after trigger fall
        wait_trig(1'b1, 3000, n);
        r2 = cyc;
        chk("period_1", r2 - r1, 2800);
        wait_trig(1'b0, 20, n);
        chk("trig_width_2", n, 12);
        wait_dv(1400, n);
        chk("timeout_lat", n, 1200);
        chk("timeout_data", data_out, EXP_FAULT);
        chk("timeout_oor", {31'd0, out_of_range}, 32'd1);
        @(negedge clk_in);
        chk("timeout_dv_single", {31'd0, data_valid}, 32'd0);

        // Overlength: 800 us echo, result at 250 us, echo outlasts the cycle
        wait_trig(1'b1, 3000, n);
        r3 = cyc;
        chk("period_2", r3 - r2, 2800);
        wait_trig(1'b0, 20, n);
        repeat (40) @(negedge clk_in);
        echo_in = 1'b1;
        wait_dv(1100, n);
        chk_rng("overlen_lat", n, 999, 1002);
        chk("overlen_data", data_out, EXP_FAULT);
        chk("overlen_oor", {31'd0, out_of_range}, 32'd1);
        repeat (3200 - n) @(negedge clk_in);
        echo_in = 1'b0;
        m = cyc;
        wait_trig(1'b1, 20, n);
        chk_rng("retrig_after_echo", cyc - m, 3, 6);

        // enable dropped mid-echo: result still reported, then no further trigger
        wait_trig(1'b0, 20, n);
        chk("trig_width_3", n, 12);
        repeat (40) @(negedge clk_in);
        echo_in = 1'b1;
        repeat (40) @(negedge clk_in);
        enable = 1'b0;
        repeat (120) @(negedge clk_in);
        echo_in = 1'b0;
        wait_dv(10, n);
        chk("disable_data", data_out, 32'h0000_0020);
        chk("disable_oor", {31'd0, out_of_range}, 32'd0);
        seen = 0;
        repeat (3500) begin
            @(negedge clk_in);
            if (trig_out) seen++;
        end
        chk("disable_idle", seen, 0);

        // rst during MEASURE
        enable = 1'b1;
        wait_trig(1'b1, 5, n);
        chk_rng("reenable_lat", n, 1, 2);
        wait_trig(1'b0, 20, n);
        repeat (40) @(negedge clk_in);
        echo_in = 1'b1;
        repeat (200) @(negedge clk_in);
        rst = 1'b1;
        @(negedge clk_in);
        chk("midrst_trig", {31'd0, trig_out}, 32'd0);
        chk("midrst_data", data_out, 32'd0);
        chk("midrst_dv", {31'd0, data_valid}, 32'd0);
        chk("midrst_oor", {31'd0, out_of_range}, 32'd0);
        rst = 1'b0; echo_in = 1'b0;
        wait_trig(1'b1, 5, n);
        chk_rng("post_rst_trig_lat", n, 1, 2);

        // rst while the trigger pulse is high drops it on that edge
        @(negedge clk_in);
        rst = 1'b1;
        @(negedge clk_in);
        chk("trig_rst_drop", {31'd0, trig_out}, 32'd0);
        rst = 1'b0;
        @(negedge clk_in);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
